ula_seq: RTL and testbench
==========================

# ula_seq

Parametrised sequential successor of the 2-bit combinational ALU. Adds N-bit signed operands, a 3-bit opcode (logic, add/sub, XOR, signed compare, iterative multiply, accumulate), a valid/ready handshake on both sides and registered results with overflow/zero/negative flags. Sits between operand sources (switches or a register file) and a consumer (display or writeback) that may apply backpressure.

## Interface
Parameters:
- N, 8, operand/result width in bits (N ≥ 4)
- CW, $clog2(N+1), multiply iteration counter width (derived, not overridden)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- F  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT, 110 MUL, 111 ACC
- A, B  in  N  signed operands
- out_valid  out  1  result registered and stable
- out_ready  in  1  consumer takes result this cycle
- SAIDA  out  N  signed result
- FLAG_O  out  1  signed overflow
- FLAG_Z  out  1  SAIDA == 0
- FLAG_N  out  1  SAIDA[N-1]

## Operation
- FSM states: IDLE, MUL_RUN, OUT. in_ready = (state == IDLE).
- Accept = in_valid && in_ready at a rising edge; F, A, B captured; later input changes ignored until the next accept.
- IDLE, accept, F ≠ MUL: result and flags registered, → OUT.
- IDLE, accept, F = MUL: load multiplier, counter = N, → MUL_RUN.
- MUL_RUN: one radix-2 Booth step per cycle, counter decrements; on the step where counter reaches 0, product low N bits and flags registered, → OUT.
- OUT: out_valid = 1; SAIDA and flags held constant; out_ready → IDLE. No accept while in OUT.
- Arithmetic, all in N-bit two's complement:
  - ADD: FLAG_O = (A[N-1] == B[N-1]) && (SAIDA[N-1] != A[N-1]); zero operands included, judged by sign bits.
  - SUB: FLAG_O = (A[N-1] != B[N-1]) && (SAIDA[N-1] != A[N-1]).
  - SLT: SAIDA = 1 if A < B signed, else 0. Correct even when A−B overflows (use diff sign XOR sub-overflow). FLAG_O = 0.
  - MUL: 2N-bit signed product P; SAIDA = P[N-1:0]; FLAG_O = 1 unless P[2N-1:N-1] is all zeros or all ones.
  - ACC: internal N-bit register ACC <= ACC + A (B ignored); SAIDA = new ACC; FLAG_O by the ADD rule with ACC as the first operand. ACC is changed only by ACC ops and reset.
  - AND/OR/XOR: FLAG_O = 0.
- FLAG_Z and FLAG_N always derive from the registered SAIDA.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, SAIDA 0, FLAG_O 0, FLAG_Z 0, FLAG_N 0, ACC 0, counter 0.
- Single-cycle ops: out_valid high in the cycle after the accept cycle.
- MUL: out_valid high N+1 cycles after the accept cycle (9 for N=8).
- Handshake: the result is consumed at the edge where out_valid && out_ready. in_ready rises the next cycle. Peak throughput is one single-cycle op per 2 cycles.
- out_ready held low: SAIDA and flags stay stable indefinitely.
- out_ready high before out_valid: no effect.
- Reset asserted mid-MUL or in OUT: immediate return to reset values. The pending result is lost and ACC is cleared.
- Reserved behaviour: none; all 8 opcodes are defined.

## Structure
- Package ula_pkg: typedef enum logic [2:0] op_t (OP_AND…OP_ACC), typedef enum state_t (IDLE, MUL_RUN, OUT).
- Sub-module booth_mult_seq: N-bit radix-2 Booth multiplier. Ports: clk, reset, start, A, B, done, product[2N-1:0]. Instantiated once. The top FSM sequences it; flag logic stays in the top.

## Test plan
- N=8, ADD 100+50 → SAIDA −106 (0x96), FLAG_O 1, FLAG_N 1, out_valid 1 cycle after accept. ADD 0+(−1) → −1, FLAG_O 0.
- SUB −128−1 → 127, FLAG_O 1. SLT A=−128, B=127 → SAIDA 1, FLAG_O 0. SLT A=127, B=−128 → 0, FLAG_Z 1.
- MUL −3×5 → −15, FLAG_O 0, out_valid exactly 9 cycles after accept. MUL 16×16 → 0, FLAG_O 1, FLAG_Z 1. MUL −128×1 → −128, FLAG_O 0.
- ACC from reset: A=100 → 100, then A=100 → −56 with FLAG_O 1, then A=56 → 0 with FLAG_Z 1. An interleaved ADD leaves ACC unchanged.
- Backpressure: hold out_ready low 3 cycles after out_valid. SAIDA and flags stay stable, in_ready stays 0, in_valid pulses are ignored. Consume → in_ready 1 next cycle.
- Assert reset 4 cycles into a MUL → all outputs at reset values, in_ready 1 after release, ACC 0. A following ADD 1+1 → 2.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared types for the sequential ALU: opcode encoding and top-level FSM states.
package ula_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101,
      OP_MUL = 3'b110,
      OP_ACC = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      MUL_RUN = 2'b01,
      OUT     = 2'b10
   } state_t;

endpackage

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one step per cycle, N steps after start.
// The partial-product high half is N+1 bits wide so that subtracting the most
// negative multiplicand cannot wrap. 'product' and 'done' describe the result of
// the step being taken this cycle, so the caller can register the final product
// on the same edge as the last step.
module booth_mult_seq #(
   parameter int unsigned N  = 8,
   parameter int unsigned CW = $clog2(N+1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic           done,
   output logic [2*N-1:0] product
);

   logic [N:0]     mcand_q;
   logic [N:0]     hi_q;
   logic [N-1:0]   lo_q;
   logic           qm1_q;
   logic [CW-1:0]  cnt_q;

   logic [N:0]     hi_sum;
   logic [2*N+1:0] shifted;

   // Booth recode of {lo[0], q-1}, then arithmetic shift right of {hi, lo, q-1}.
   always_comb begin
      hi_sum = hi_q;
      unique case ({lo_q[0], qm1_q})
         2'b01:   hi_sum = hi_q + mcand_q;
         2'b10:   hi_sum = hi_q - mcand_q;
         default: hi_sum = hi_q;
      endcase
      shifted = {hi_sum[N], hi_sum, lo_q};
      product = shifted[2*N:1];
      done    = (cnt_q == CW'(1));
   end

   // Load operands on start, otherwise step while the counter is non-zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (start) begin
         mcand_q <= {A[N-1], A};
         hi_q    <= '0;
         lo_q    <= B;
         qm1_q   <= 1'b0;
         cnt_q   <= CW'(N);
      end else if (cnt_q != '0) begin
         hi_q    <= shifted[2*N+1:N+1];
         lo_q    <= shifted[N:1];
         qm1_q   <= shifted[0];
         cnt_q   <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/ula_seq.sv
// Sequential N-bit ALU with valid/ready on both sides, registered result and
// overflow/zero/negative flags. Single-cycle ops complete on the accept edge;
// MUL runs through the Booth multiplier and completes N cycles later.
module ula_seq
   import ula_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned CW = $clog2(N+1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   F,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] SAIDA,
   output logic         FLAG_O,
   output logic         FLAG_Z,
   output logic         FLAG_N
);

   state_t         state_q, state_d;
   logic [N-1:0]   saida_q, saida_d;
   logic           flag_o_q, flag_o_d;
   logic           flag_z_q, flag_z_d;
   logic           flag_n_q, flag_n_d;
   logic [N-1:0]   acc_q, acc_d;

   op_t            op;
   logic [N-1:0]   sum, diff, acc_sum;
   logic           add_ovf, sub_ovf, acc_ovf, slt;
   logic [N-1:0]   alu_res;
   logic           alu_ovf;

   logic           mul_start;
   logic           mul_done;
   logic [2*N-1:0] mul_product;
   logic [N:0]     mul_hi;
   logic           mul_ovf;

   logic           load;
   logic [N-1:0]   res;
   logic           ovf;

   booth_mult_seq #(
      .N  (N),
      .CW (CW)
   ) u_mult (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .A       (A),
      .B       (B),
      .done    (mul_done),
      .product (mul_product)
   );

   // Arithmetic datapath and signed-overflow detection for the single-cycle ops.
   always_comb begin
      op      = op_t'(F);
      sum     = A + B;
      diff    = A - B;
      acc_sum = acc_q + A;
      add_ovf = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
      sub_ovf = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
      acc_ovf = (acc_q[N-1] == A[N-1]) && (acc_sum[N-1] != acc_q[N-1]);
      // Sign of the difference is wrong exactly when the subtraction overflowed.
      slt     = diff[N-1] ^ sub_ovf;
      // Product fits in N bits iff its top N+1 bits are a pure sign extension.
      mul_hi  = mul_product[2*N-1:N-1];
      mul_ovf = !((&mul_hi) || (~|mul_hi));
      alu_res = '0;
      alu_ovf = 1'b0;
      unique case (op)
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_ADD:  begin alu_res = sum;     alu_ovf = add_ovf; end
         OP_SUB:  begin alu_res = diff;    alu_ovf = sub_ovf; end
         OP_XOR:  alu_res = A ^ B;
         OP_SLT:  alu_res = {{(N-1){1'b0}}, slt};
         OP_MUL:  alu_res = '0;
         OP_ACC:  begin alu_res = acc_sum; alu_ovf = acc_ovf; end
         default: alu_res = '0;
      endcase
   end

   // Next-state logic: accept in IDLE, wait for the multiplier, hold in OUT.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mul_start = 1'b0;
      load      = 1'b0;
      res       = alu_res;
      ovf       = alu_ovf;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (op == OP_MUL) begin
                  mul_start = 1'b1;
                  state_d   = MUL_RUN;
               end else begin
                  load    = 1'b1;
                  state_d = OUT;
                  if (op == OP_ACC) acc_d = acc_sum;
               end
            end
         end
         MUL_RUN: begin
            if (mul_done) begin
               load    = 1'b1;
               res     = mul_product[N-1:0];
               ovf     = mul_ovf;
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      saida_d  = load ? res : saida_q;
      flag_o_d = load ? ovf : flag_o_q;
      flag_z_d = load ? (res == '0) : flag_z_q;
      flag_n_d = load ? res[N-1] : flag_n_q;
   end

   // State, result, flag and accumulator registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         saida_q  <= '0;
         flag_o_q <= 1'b0;
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         saida_q  <= saida_d;
         flag_o_q <= flag_o_d;
         flag_z_q <= flag_z_d;
         flag_n_q <= flag_n_d;
         acc_q    <= acc_d;
      end
   end

   // Handshake and result outputs.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == OUT);
      SAIDA     = saida_q;
      FLAG_O    = flag_o_q;
      FLAG_Z    = flag_z_q;
      FLAG_N    = flag_n_q;
   end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (N=8): an integer-range reference model pushes
// expected results to a scoreboard when an op is issued; they are popped and
// compared when out_valid rises.
module tb_ula_seq;
   import ula_pkg::*;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   F;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] SAIDA;
   logic         FLAG_O;
   logic         FLAG_Z;
   logic         FLAG_N;

   ula_seq #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .F         (F),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .SAIDA     (SAIDA),
      .FLAG_O    (FLAG_O),
      .FLAG_Z    (FLAG_Z),
      .FLAG_N    (FLAG_N)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int model_acc = 0;

   typedef struct {
      string        tag;
      logic [N-1:0] saida;
      logic         o;
      int           lat;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model on plain integers: overflow means "true result outside N-bit range".
   task automatic push_exp(input string tag, input logic [2:0] f, input int a, input int b);
      exp_t e;
      int   r;
      logic signed [N-1:0] w;
      e.tag = tag;
      e.o   = 1'b0;
      e.lat = 1;
      r     = 0;
      case (f)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: begin r = a + b; e.o = (r > 127) || (r < -128); end
         3'b011: begin r = a - b; e.o = (r > 127) || (r < -128); end
         3'b100: r = a ^ b;
         3'b101: r = (a < b) ? 1 : 0;
         3'b110: begin r = a * b; e.o = (r > 127) || (r < -128); e.lat = N + 1; end
         default: begin
            r = model_acc + a;
            e.o = (r > 127) || (r < -128);
            w = r[N-1:0];
            model_acc = int'(w);
         end
      endcase
      e.saida = r[N-1:0];
      sb.push_back(e);
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input int a, input int b,
                         input int stall);
      int   cyc;
      exp_t e;
      @(negedge clk);
      check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      F = f;
      A = a[N-1:0];
      B = b[N-1:0];
      push_exp(tag, f, a, b);
      @(posedge clk);
      #1;
      // Later input changes must be ignored.
      in_valid = 1'b0;
      A = N'($urandom);
      B = N'($urandom);
      F = 3'($urandom);
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         // Early out_ready while busy must have no effect.
         out_ready = (cyc == 3);
         @(posedge clk);
         #1;
         cyc++;
      end
      out_ready = 1'b0;
      e = sb.pop_front();
      check({e.tag, ".latency"}, 32'(cyc), 32'(e.lat));
      check({e.tag, ".saida"}, 32'(SAIDA), 32'(e.saida));
      check({e.tag, ".flag_o"}, {31'd0, FLAG_O}, {31'd0, e.o});
      check({e.tag, ".flag_z"}, {31'd0, FLAG_Z}, {31'd0, (e.saida == '0)});
      check({e.tag, ".flag_n"}, {31'd0, FLAG_N}, {31'd0, e.saida[N-1]});
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         F = OP_ADD;
         A = 8'd1;
         B = 8'd1;
         @(posedge clk);
         #1;
         check({e.tag, ".hold_saida"}, 32'(SAIDA), 32'(e.saida));
         check({e.tag, ".hold_o"}, {31'd0, FLAG_O}, {31'd0, e.o});
         check({e.tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
         check({e.tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({e.tag, ".consumed"}, {31'd0, out_valid}, 32'd0);
      check({e.tag, ".ready_after"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".saida"}, 32'(SAIDA), 32'd0);
      check({tag, ".flags"}, {29'd0, FLAG_O, FLAG_Z, FLAG_N}, 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      F = '0;
      A = '0;
      B = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      run_op("add_100_50",   OP_ADD, 100, 50, 0);
      run_op("add_0_m1",     OP_ADD, 0, -1, 0);
      run_op("sub_m128_1",   OP_SUB, -128, 1, 0);
      run_op("slt_m128_127", OP_SLT, -128, 127, 0);
      run_op("slt_127_m128", OP_SLT, 127, -128, 0);
      run_op("mul_m3_5",     OP_MUL, -3, 5, 0);
      run_op("mul_16_16",    OP_MUL, 16, 16, 0);
      run_op("mul_m128_1",   OP_MUL, -128, 1, 0);
      run_op("mul_m128_m128", OP_MUL, -128, -128, 0);
      run_op("acc_100a",     OP_ACC, 100, 7, 0);
      run_op("acc_100b",     OP_ACC, 100, -9, 0);
      run_op("add_between",  OP_ADD, 3, 4, 0);
      run_op("acc_56",       OP_ACC, 56, 0, 0);
      run_op("and",          OP_AND, 90, 15, 0);
      run_op("or",           OP_OR, -96, 5, 0);
      run_op("xor_zero",     OP_XOR, 85, 85, 0);
      run_op("backpressure", OP_ACC, 7, 0, 3);

      // Reset four cycles into a multiply.
      @(negedge clk);
      in_valid = 1'b1;
      F = OP_MUL;
      A = 8'd7;
      B = 8'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_mul_reset");
      @(negedge clk);
      reset = 1'b0;
      model_acc = 0;
      #1;
      check("post_reset.in_ready", {31'd0, in_ready}, 32'd1);
      run_op("acc_after_reset", OP_ACC, 5, 0, 0);
      run_op("add_1_1",         OP_ADD, 1, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
